mini_sys_array: RTL and testbench
=================================

# mini_sys_array

2×4 by 4×2 signed matrix-multiply engine built as a 2×2 output-stationary systolic array of MAC processing elements. It is the small datapath kernel of the self-attention pipeline that produces a 2×2 score tile. It also produces an "importance" value, the sum of the tile. A `done` flag tells the controller when the tile is final.

## Interface
- `WIDTH`, default 8: operand width in bits, signed two's complement.
- `K`, default 4: inner dimension, fixed for this block.
- `clk`  in  1  rising-edge clock.
- `_reset`  in  1  asynchronous, active-high reset. Clears the step counter, all accumulators and `done`.
- `enable`  in  1  when high, the array advances one step per clock. When low, all state holds.
- `intMul`  in  1  selects the arithmetic mode.
  - 1: integer mode, full product.
  - 0: Q4.4 fixed-point mode, each product arithmetically shifted right by 4.
- `a00..a03`  in  WIDTH each  matrix A, row 0, k=0..3.
- `a10..a13`  in  WIDTH each  matrix A, row 1.
- `b1_00,b1_10,b1_20,b1_30`  in  WIDTH each  matrix B, column 0, k=0..3.
- `b1_01,b1_11,b1_21,b1_31`  in  WIDTH each  matrix B, column 1.
- `result0`  out  2·WIDTH  C[0][0] = row0·col0.
- `result1`  out  2·WIDTH  C[0][1] = row0·col1.
- `result2`  out  2·WIDTH  C[1][0] = row1·col0.
- `result3`  out  2·WIDTH  C[1][1] = row1·col1.
- `importance`  out  2·WIDTH  result0+result1+result2+result3.
- `done`  out  1  high when all four results are final.

## Operation
- All operand inputs must be held stable for the whole operation. The block selects operand k internally from a step counter; it does not capture a snapshot.
- A 3-bit step counter `t` counts 0 to 6 and saturates at 6.
- Skew: PE(i,j) uses k = t−i−j when 0 ≤ k ≤ 3. Otherwise it adds nothing.
  - A values propagate right and B values propagate down through one register per PE.
  - Feeding the same operands through the skew-based mux is an equivalent implementation and is permitted.
- Each PE:
  - product = a·b, signed, 2·WIDTH bits.
  - If `intMul`=0, product = product >>> 4 (arithmetic shift).
  - acc ← acc + product, with 2·WIDTH two's-complement wrap and no saturation.
- `resultN` outputs the accumulator registers directly, so partial sums are visible while the operation runs.
- `importance` is the combinational 2·WIDTH wrap-around sum of the four accumulators. It is valid when `done`=1.
- Once `t`=6, the accumulators stop updating and hold until reset.
- A new operation requires a `_reset` pulse. There is no auto-restart.
- `intMul` must be held constant during an operation. A change mid-operation affects only the products from that step onward.

## Timing
- Reset values: `result0..3`=0, `importance`=0, `done`=0, `t`=0. Reset acts immediately and asynchronously.
- Steps advance on each rising edge with `enable`=1: PE(0,0) on steps 0–3, PE(0,1) and PE(1,0) on steps 1–4, PE(1,1) on steps 2–5.
- Latency:
  - result0 is final after 4 enabled edges.
  - result1 and result2 are final after 5.
  - result3 is final after 6.
  - `done` is registered and rises on the 6th enabled edge, at the same edge that makes result3 final.
- `enable` low freezes the counter, accumulators and `done`. Latency counts only enabled edges.
- Reset mid-operation aborts the operation. All outputs return to 0 and the next operation starts at step 0.
- `done` stays high until reset.

## Structure
- Shared package `mini_sa_pkg` holds the constants: WIDTH=8, ACC_W=2*WIDTH, K=4, LAST_STEP=6, FRAC_BITS=4.
- Sub-module `mini_sa_pe` is the MAC processing element. It has the clock, reset, enable, a valid/advance signal, `a_in`, `b_in`, `intMul`, `a_out`, `b_out` and `acc`. It is instantiated four times.
- The top level contains the step counter, the skew/operand mux, the `done` register and the importance adder.

## Test plan
- A row0=[1,0,1,0], row1=0, B all 1, `intMul`=1: after 6 edges, result0=2, result1=2, result2=0, result3=0, importance=4, `done`=1 exactly at the 6th edge.
- Same operands but row1=[1,1,1,1], applied after a `_reset` pulse: result0=2, result1=2, result2=4, result3=4, importance=12.
- a00=a01=0x7F, others 0, B col0 all 0x7F: result0=0x7E02. Then set B col0 all 0x80 with a00..a03=0x80 (-128): result0 wraps to 0x0000.
- `intMul`=0, a00=0x10, b1_00=0x20, all else 0: result0=0x0020, the others 0, importance=0x0020.
- Hold `enable`=0 for 3 cycles after step 2: outputs and `done` freeze, and `done` rises after exactly 6 enabled edges.
- Assert `_reset` at step 3: all outputs drop to 0 immediately. After release, a full 6-step operation yields correct results.

Source files
------------

// File: rtl/mini_sa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mini_sa_pkg
// Description : Shared constants for the 2x2 systolic matrix-multiply kernel.
// Revision    : 1.0 - initial release
// ============================================================================
package mini_sa_pkg;
  localparam int WIDTH     = 8;          // operand width, signed
  localparam int ACC_W     = 2 * WIDTH;  // accumulator / result width
  localparam int K         = 4;          // inner dimension
  localparam int LAST_STEP = 6;          // step count at which the tile is final
  localparam int FRAC_BITS = 4;          // Q4.4 fraction bits
  localparam int STEP_W    = 3;          // step counter width (0..6)
endpackage
`default_nettype wire

// File: rtl/mini_sa_pe.sv
`default_nettype none
// ============================================================================
// Module      : mini_sa_pe
// Description : MAC processing element. Passes A right and B down through one
//               register each and accumulates a*b (optionally Q4.4 scaled).
// Revision    : 1.0 - initial release
// ============================================================================
module mini_sa_pe
  import mini_sa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 valid,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic                 intMul,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic [2*WIDTH-1:0]   acc
);
  localparam int ACC_W = 2 * WIDTH;

  logic signed [ACC_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_term;

  // Full signed product, then optional arithmetic scaling for Q4.4 mode.
  always_comb begin
    w_prod = $signed({{WIDTH{a_in[WIDTH-1]}}, a_in}) *
             $signed({{WIDTH{b_in[WIDTH-1]}}, b_in});
    w_term = intMul ? w_prod : (w_prod >>> FRAC_BITS);
  end

  // Operand pass-through registers advance every enabled step so the skew
  // between neighbouring PEs stays exactly one step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
    end else if (en) begin
      a_out <= a_in;
      b_out <= b_in;
    end
  end

  // Accumulate only on the steps where this PE owns a valid k; wraps freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (valid) begin
      acc <= acc + w_term;
    end
  end
endmodule
`default_nettype wire

// File: rtl/mini_sys_array.sv
`default_nettype none
// ============================================================================
// Module      : mini_sys_array
// Description : 2x4 by 4x2 signed matrix multiply on a 2x2 output-stationary
//               systolic array. Produces four results, their sum
//               (importance) and a done flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mini_sys_array
  import mini_sa_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K     = 4
) (
  input  logic                 clk,
  input  logic                 _reset,
  input  logic                 enable,
  input  logic                 intMul,
  input  logic [WIDTH-1:0]     a00, a01, a02, a03,
  input  logic [WIDTH-1:0]     a10, a11, a12, a13,
  input  logic [WIDTH-1:0]     b1_00, b1_10, b1_20, b1_30,
  input  logic [WIDTH-1:0]     b1_01, b1_11, b1_21, b1_31,
  output logic [2*WIDTH-1:0]   result0,
  output logic [2*WIDTH-1:0]   result1,
  output logic [2*WIDTH-1:0]   result2,
  output logic [2*WIDTH-1:0]   result3,
  output logic [2*WIDTH-1:0]   importance,
  output logic                 done
);
  localparam int ACC_W = 2 * WIDTH;

  logic [STEP_W-1:0] r_t;
  logic              r_done;

  // Operands gathered into arrays indexed by row/column and k.
  logic [WIDTH-1:0] w_a [0:1][0:K-1];
  logic [WIDTH-1:0] w_b [0:1][0:K-1];   // w_b[col][k]

  // Horizontal A links: [row][0] is the array edge, [row][j+1] is PE(row,j) out.
  logic [WIDTH-1:0] w_ah [0:1][0:2];
  // Vertical B links: [0][col] is the array edge, [i+1][col] is PE(i,col) out.
  logic [WIDTH-1:0] w_bv [0:2][0:1];
  logic [ACC_W-1:0] w_acc [0:3];

  assign w_a[0][0] = a00;   assign w_a[0][1] = a01;
  assign w_a[0][2] = a02;   assign w_a[0][3] = a03;
  assign w_a[1][0] = a10;   assign w_a[1][1] = a11;
  assign w_a[1][2] = a12;   assign w_a[1][3] = a13;
  assign w_b[0][0] = b1_00; assign w_b[0][1] = b1_10;
  assign w_b[0][2] = b1_20; assign w_b[0][3] = b1_30;
  assign w_b[1][0] = b1_01; assign w_b[1][1] = b1_11;
  assign w_b[1][2] = b1_21; assign w_b[1][3] = b1_31;

  // Step counter: advances on enabled edges and saturates at the last step.
  always_ff @(posedge clk or posedge _reset) begin
    if (_reset) begin
      r_t <= '0;
    end else if (enable && (r_t != STEP_W'(LAST_STEP))) begin
      r_t <= r_t + STEP_W'(1);
    end
  end

  // Done rises on the edge that moves the counter onto the last step.
  always_ff @(posedge clk or posedge _reset) begin
    if (_reset) begin
      r_done <= 1'b0;
    end else if (enable && (r_t == STEP_W'(LAST_STEP - 1))) begin
      r_done <= 1'b1;
    end
  end

  // Left edge of each row: feed A[row][t-row] while in range, else zero.
  for (genvar i = 0; i < 2; i++) begin : g_row_feed
    logic [STEP_W-1:0] w_k;
    logic [WIDTH-1:0]  w_val;
    // Skewed k selection for this row.
    always_comb begin
      w_k   = r_t - STEP_W'(i);
      w_val = '0;
      if ((r_t >= STEP_W'(i)) && (w_k < STEP_W'(K)))
        w_val = w_a[i][w_k[1:0]];
    end
    assign w_ah[i][0] = w_val;
  end

  // Top edge of each column: feed B[t-col][col] while in range, else zero.
  for (genvar j = 0; j < 2; j++) begin : g_col_feed
    logic [STEP_W-1:0] w_k;
    logic [WIDTH-1:0]  w_val;
    // Skewed k selection for this column.
    always_comb begin
      w_k   = r_t - STEP_W'(j);
      w_val = '0;
      if ((r_t >= STEP_W'(j)) && (w_k < STEP_W'(K)))
        w_val = w_b[j][w_k[1:0]];
    end
    assign w_bv[0][j] = w_val;
  end

  // PE grid; PE(i,j) is valid when k = t-i-j lies in 0..K-1.
  for (genvar i = 0; i < 2; i++) begin : g_pe_row
    for (genvar j = 0; j < 2; j++) begin : g_pe_col
      logic [STEP_W-1:0] w_d;
      logic              w_valid;
      assign w_d     = r_t - STEP_W'(i + j);
      assign w_valid = enable && (r_t >= STEP_W'(i + j)) && (w_d < STEP_W'(K));

      mini_sa_pe #(.WIDTH(WIDTH)) u_pe (
        .clk    (clk),
        .rst    (_reset),
        .en     (enable),
        .valid  (w_valid),
        .a_in   (w_ah[i][j]),
        .b_in   (w_bv[i][j]),
        .intMul (intMul),
        .a_out  (w_ah[i][j+1]),
        .b_out  (w_bv[i+1][j]),
        .acc    (w_acc[2*i + j])
      );
    end
  end

  assign result0    = w_acc[0];
  assign result1    = w_acc[1];
  assign result2    = w_acc[2];
  assign result3    = w_acc[3];
  assign importance = w_acc[0] + w_acc[1] + w_acc[2] + w_acc[3];
  assign done       = r_done;
endmodule
`default_nettype wire

// File: tb/tb_mini_sys_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_mini_sys_array
// Description : Self-checking bench for mini_sys_array with a matrix-level
//               reference model of the partial and final results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mini_sys_array;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        im;
  logic [7:0]  ma [0:1][0:3];   // A[row][k]
  logic [7:0]  mb [0:3][0:1];   // B[k][col]
  logic [15:0] res [0:3];
  logic [15:0] result0, result1, result2, result3, importance;
  logic        done;

  int nvec = 0;
  int nerr = 0;
  int n    = 0;   // enabled edges since last reset

  always #5 clk = ~clk;

  assign res[0] = result0;
  assign res[1] = result1;
  assign res[2] = result2;
  assign res[3] = result3;

  mini_sys_array dut (
    .clk(clk), ._reset(rst), .enable(enable), .intMul(im),
    .a00(ma[0][0]), .a01(ma[0][1]), .a02(ma[0][2]), .a03(ma[0][3]),
    .a10(ma[1][0]), .a11(ma[1][1]), .a12(ma[1][2]), .a13(ma[1][3]),
    .b1_00(mb[0][0]), .b1_10(mb[1][0]), .b1_20(mb[2][0]), .b1_30(mb[3][0]),
    .b1_01(mb[0][1]), .b1_11(mb[1][1]), .b1_21(mb[2][1]), .b1_31(mb[3][1]),
    .result0(result0), .result1(result1), .result2(result2), .result3(result3),
    .importance(importance), .done(done)
  );

  // C[i][j] after `edges` enabled edges: PE(i,j) has consumed k < edges-i-j.
  function automatic logic [15:0] exp_c(input int i, input int j, input int edges);
    logic [15:0] s = 16'h0;
    for (int k = 0; k < 4; k++) begin
      if (k < edges - i - j) begin
        int p = int'($signed(ma[i][k])) * int'($signed(mb[k][j]));
        if (!im) p = p >>> 4;
        s = s + p[15:0];
      end
    end
    return s;
  endfunction

  function automatic logic [15:0] exp_imp(input int edges);
    return exp_c(0, 0, edges) + exp_c(0, 1, edges) + exp_c(1, 0, edges) + exp_c(1, 1, edges);
  endfunction

  task automatic pulse_reset;
    rst = 1'b1; #2; rst = 1'b0; n = 0;
  endtask

  task automatic step(input logic en);
    enable = en;
    @(posedge clk); #1;
    if (en) n++;
    enable = 1'b0;
  endtask

  task automatic load(input logic [31:0] r0, input logic [31:0] r1,
                      input logic [31:0] c0, input logic [31:0] c1);
    for (int k = 0; k < 4; k++) begin
      ma[0][k] = r0[8*k +: 8];
      ma[1][k] = r1[8*k +: 8];
      mb[k][0] = c0[8*k +: 8];
      mb[k][1] = c1[8*k +: 8];
    end
  endtask

  task automatic load_random;
    for (int k = 0; k < 4; k++) begin
      ma[0][k] = 8'($urandom); ma[1][k] = 8'($urandom);
      mb[k][0] = 8'($urandom); mb[k][1] = 8'($urandom);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; im = 1'b1;
    load(32'h0, 32'h0, 32'h0, 32'h0);
    #3;
    for (int r = 0; r < 4; r++) begin
      nvec++;
      if (res[r] !== 16'h0) begin
        nerr++; $display("FAIL reset result%0d: got %h want 0000", r, res[r]);
      end
    end
    nvec++;
    if (importance !== 16'h0) begin nerr++; $display("FAIL reset importance: got %h want 0000", importance); end
    nvec++;
    if (done !== 1'b0) begin nerr++; $display("FAIL reset done: got %b want 0", done); end
    @(negedge clk); rst = 1'b0; n = 0;
  endtask

  // Runs `edges` enabled edges checking every output against the model each edge.
  task automatic run_checked(input string name, input int edges);
    for (int e = 0; e < edges; e++) begin
      step(1'b1);
      for (int r = 0; r < 4; r++) begin
        nvec++;
        if (res[r] !== exp_c(r / 2, r % 2, n)) begin
          nerr++;
          $display("FAIL %s result%0d edge %0d: got %h want %h", name, r, n, res[r], exp_c(r / 2, r % 2, n));
        end
      end
      nvec++;
      if (importance !== exp_imp(n)) begin
        nerr++; $display("FAIL %s importance edge %0d: got %h want %h", name, n, importance, exp_imp(n));
      end
      nvec++;
      if (done !== (n >= 6)) begin
        nerr++; $display("FAIL %s done edge %0d: got %b want %b", name, n, done, (n >= 6));
      end
    end
  endtask

  task automatic test_directed;
    logic [15:0] want [0:4];
    logic [15:0] want_imp;
    for (int v = 0; v < 5; v++) begin
      im = 1'b1;
      case (v)
        0: begin load(32'h00010001, 32'h0, 32'h01010101, 32'h01010101);
                 want = '{16'd2, 16'd2, 16'd0, 16'd0, 16'd4}; end
        1: begin load(32'h00010001, 32'h01010101, 32'h01010101, 32'h01010101);
                 want = '{16'd2, 16'd2, 16'd4, 16'd4, 16'd12}; end
        2: begin load(32'h00007F7F, 32'h0, 32'h7F7F7F7F, 32'h0);
                 want = '{16'h7E02, 16'h0, 16'h0, 16'h0, 16'h7E02}; end
        3: begin load(32'h80808080, 32'h0, 32'h80808080, 32'h0);
                 want = '{16'h0000, 16'h0, 16'h0, 16'h0, 16'h0000}; end
        default: begin im = 1'b0; load(32'h00000010, 32'h0, 32'h00000020, 32'h0);
                 want = '{16'h0020, 16'h0, 16'h0, 16'h0, 16'h0020}; end
      endcase
      pulse_reset;
      run_checked("directed", 7);
      for (int r = 0; r < 4; r++) begin
        nvec++;
        if (res[r] !== want[r]) begin
          nerr++; $display("FAIL directed%0d final result%0d: got %h want %h", v, r, res[r], want[r]);
        end
      end
      want_imp = want[4];
      nvec++;
      if (importance !== want_imp) begin
        nerr++; $display("FAIL directed%0d final importance: got %h want %h", v, importance, want_imp);
      end
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 25; it++) begin
      load_random;
      im = 1'($urandom);
      pulse_reset;
      run_checked("random", 8);
    end
  endtask

  task automatic test_enable_stall;
    logic [15:0] held [0:3];
    logic        held_done;
    for (int it = 0; it < 4; it++) begin
      load_random;
      im = 1'($urandom);
      pulse_reset;
      run_checked("stall_pre", 2 + it);
      for (int r = 0; r < 4; r++) held[r] = res[r];
      held_done = done;
      for (int c = 0; c < 3; c++) begin
        step(1'b0);
        for (int r = 0; r < 4; r++) begin
          nvec++;
          if (res[r] !== held[r]) begin
            nerr++; $display("FAIL stall hold result%0d: got %h want %h", r, res[r], held[r]);
          end
        end
        nvec++;
        if (done !== held_done) begin
          nerr++; $display("FAIL stall hold done: got %b want %b", done, held_done);
        end
      end
      run_checked("stall_post", 7 - n);
    end
  endtask

  task automatic test_reset_mid;
    for (int it = 0; it < 3; it++) begin
      load_random;
      im = 1'($urandom);
      pulse_reset;
      run_checked("mid_pre", 3);
      rst = 1'b1;
      #1;
      for (int r = 0; r < 4; r++) begin
        nvec++;
        if (res[r] !== 16'h0) begin
          nerr++; $display("FAIL midreset result%0d: got %h want 0000", r, res[r]);
        end
      end
      nvec++;
      if (importance !== 16'h0) begin nerr++; $display("FAIL midreset importance: got %h want 0000", importance); end
      nvec++;
      if (done !== 1'b0) begin nerr++; $display("FAIL midreset done: got %b want 0", done); end
      #1; rst = 1'b0; n = 0;
      load_random;
      run_checked("mid_post", 7);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_enable_stall;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
`default_nettype wire
